// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types for the instruction front end
//
// Purpose: address/instruction widths and the fetch queue entry layout
// shared by the fetcher, the instruction queue and decode.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] Addr;
  typedef logic [31:0]     Inst;

  typedef struct packed {
    Addr addr;
    Inst bits;
  } FetchEntry;

  // Sequential fetch step; wraps modulo 2^XLEN.
  function automatic Addr next_fetch_addr(input Addr a);
    return a + Addr'(4);
  endfunction

endpackage

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - instruction fetch front end feeding the instruction queue
//
// Purpose: issues word fetches to the instruction memory bus (at most one
// outstanding) and writes {addr, bits} entries into the instruction queue.
// Execute-stage redirects flush the queue and restart fetch at the target.
//
// Ports:
//   clk                     core clock, all state on rising edge
//   rst                     asynchronous active-low reset
//   membus_valid/ready      request handshake (valid never depends on ready)
//   membus_addr             request address (word aligned)
//   membus_rvalid/rdata     in-order response, one per accepted request
//   fifo_wvalid/wdata       queue write side
//   fifo_wready(_two)       queue has at least one / two free slots
//   fifo_flush              queue flush, combinational from control_hazard
//   control_hazard(_pc_next) redirect request and target from execute
module inst_fetcher
  import cpu_pkg::*;
#(
  parameter Addr RESET_VECTOR = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  output logic      membus_valid,
  input  logic      membus_ready,
  output Addr       membus_addr,
  input  logic      membus_rvalid,
  input  Inst       membus_rdata,
  output logic      fifo_wvalid,
  input  logic      fifo_wready,
  input  logic      fifo_wready_two,
  output FetchEntry fifo_wdata,
  output logic      fifo_flush,
  input  logic      control_hazard,
  input  Addr       control_hazard_pc_next
);

  Addr       pc;
  Addr       req_addr;
  logic      pending;
  logic      discard;
  logic      obuf_valid;
  FetchEntry obuf;

  logic      issue_ok;
  logic      accept;
  logic      stale_in_flight;

  // Requiring two free queue slots reserves room for both the buffered
  // entry and the response still in flight, so responses never stall.
  assign issue_ok = !control_hazard
                 && (!pending || membus_rvalid)
                 && (!obuf_valid || fifo_wready)
                 && fifo_wready_two;

  assign membus_valid = issue_ok;
  assign membus_addr  = pc;
  assign accept       = issue_ok && membus_ready;

  assign fifo_wvalid  = obuf_valid;
  assign fifo_wdata   = obuf;
  assign fifo_flush   = control_hazard;

  // A redirect while a response is still owed leaves a stale word on the
  // bus; it must be swallowed when it eventually arrives.
  assign stale_in_flight = pending && !membus_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_VECTOR;
      req_addr   <= '0;
      pending    <= 1'b0;
      discard    <= 1'b0;
      obuf_valid <= 1'b0;
      obuf       <= '0;
    end else if (control_hazard) begin
      // Redirect wins: any same-cycle response is dropped, no issue.
      pc         <= control_hazard_pc_next;
      obuf_valid <= 1'b0;
      pending    <= stale_in_flight;
      discard    <= stale_in_flight;
    end else begin
      if (accept) begin
        req_addr <= pc;
        pc       <= next_fetch_addr(pc);
      end

      if (accept) begin
        pending <= 1'b1;
      end else if (membus_rvalid) begin
        pending <= 1'b0;
      end

      if (membus_rvalid && discard) begin
        discard <= 1'b0;
      end

      if (membus_rvalid && !discard) begin
        obuf       <= '{addr: req_addr, bits: membus_rdata};
        obuf_valid <= 1'b1;
      end else if (fifo_wready) begin
        obuf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - scoreboard bench for inst_fetcher
module tb_inst_fetcher;
  import cpu_pkg::*;

  localparam Addr RV    = 32'h0000_0000;
  localparam int  DEPTH = 3;

  logic      clk = 1'b0;
  logic      rst;
  logic      membus_valid, membus_ready, membus_rvalid;
  Addr       membus_addr;
  Inst       membus_rdata;
  logic      fifo_wvalid, fifo_wready, fifo_wready_two, fifo_flush;
  FetchEntry fifo_wdata;
  logic      control_hazard;
  Addr       control_hazard_pc_next;

  inst_fetcher #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst),
    .membus_valid(membus_valid), .membus_ready(membus_ready),
    .membus_addr(membus_addr), .membus_rvalid(membus_rvalid),
    .membus_rdata(membus_rdata),
    .fifo_wvalid(fifo_wvalid), .fifo_wready(fifo_wready),
    .fifo_wready_two(fifo_wready_two), .fifo_wdata(fifo_wdata),
    .fifo_flush(fifo_flush), .control_hazard(control_hazard),
    .control_hazard_pc_next(control_hazard_pc_next)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: every accepted fetch owes one queue entry, in order,
  // unless a redirect occurs before that entry is written.
  FetchEntry exp_q[$];
  Addr       exp_pc;
  // Memory model: one outstanding request, response after wt idle cycles.
  bit        busy;
  int        wt;
  Addr       maddr;
  // Queue model driving wready/wready_two.
  int        qcnt;

  int  cyc = 0;
  int  p_ready = 100, p_rd = 100, p_haz = 0, wmax = 0;
  bit  haz_on_rv = 0, force_haz = 0;
  Addr force_tgt = '0;
  bit  mon_en = 0;
  bit  prev_stall = 0;
  FetchEntry prev_data;
  bit  prev_hz_clean = 0;

  int  acc_cyc[$];
  Addr acc_addr[$];
  int  first_wr_cyc = -1;
  bit  seen_wrap = 0;
  bit  have_last = 0;
  Addr last_acc;
  int  n_hz_pend = 0, n_hz_rv = 0;

  function automatic Inst mem_word(input Addr a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    #3;
    mon_en = 0;
    rst = 1'b0;
    membus_ready = 0; membus_rvalid = 0; membus_rdata = '0;
    control_hazard = 0; control_hazard_pc_next = '0;
    fifo_wready = 1; fifo_wready_two = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wvalid", fifo_wvalid, 0);
    check("rst_wdata", fifo_wdata, 0);
    check("rst_addr", membus_addr, RV);
    check("rst_flush", fifo_flush, 0);
    check("rst_valid_follows_space", membus_valid, 1);
    busy = 0; wt = 0; qcnt = 0; exp_q.delete(); exp_pc = RV;
    prev_stall = 0; prev_hz_clean = 0; have_last = 0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1;
  endtask

  task automatic cycle();
    logic acc, wr, rd;
    Addr  tgt;
    @(negedge clk);
    membus_rvalid   = busy && (wt == 0);
    membus_rdata    = membus_rvalid ? mem_word(maddr) : Inst'($urandom);
    membus_ready    = ($urandom_range(1, 100) <= p_ready);
    fifo_wready     = (DEPTH - qcnt) >= 1;
    fifo_wready_two = (DEPTH - qcnt) >= 2;
    control_hazard  = force_haz || (haz_on_rv && membus_rvalid)
                   || ($urandom_range(1, 100) <= p_haz);
    tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    if (force_haz) tgt = force_tgt;
    control_hazard_pc_next = control_hazard ? tgt : Addr'($urandom);
    #1;
    check("flush", fifo_flush, control_hazard);
    check("issue_gate", membus_valid &&
          (control_hazard || !fifo_wready_two || (busy && !membus_rvalid)), 0);
    if (membus_valid) check("membus_addr", membus_addr, exp_pc);
    if (prev_hz_clean && !control_hazard && fifo_wready_two)
      check("reissue_after_redirect", membus_valid, 1);
    prev_hz_clean = control_hazard && (!busy || membus_rvalid);
    if (control_hazard && busy && !membus_rvalid) n_hz_pend++;
    if (control_hazard && membus_rvalid) n_hz_rv++;

    acc = membus_valid && membus_ready;
    wr  = fifo_wvalid && fifo_wready;
    rd  = (qcnt > 0) && ($urandom_range(1, 100) <= p_rd);

    if (membus_rvalid) busy = 0;
    else if (busy) wt--;
    if (acc) begin
      exp_q.push_back({membus_addr, mem_word(membus_addr)});
      if (have_last && last_acc == 32'hFFFF_FFFC && membus_addr == 32'h0) seen_wrap = 1;
      last_acc = membus_addr; have_last = 1;
      acc_cyc.push_back(cyc); acc_addr.push_back(membus_addr);
      busy = 1; maddr = membus_addr; wt = $urandom_range(0, wmax);
      exp_pc = exp_pc + 32'd4;
    end
    if (control_hazard) begin
      exp_q.delete();
      exp_pc = control_hazard_pc_next;
      have_last = 0;
      qcnt = 0;
    end else begin
      qcnt = qcnt + int'(wr) - int'(rd);
    end
    cyc++;
  endtask

  // Monitor: compares every queue write against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      if (prev_stall && !control_hazard) begin
        check("hold_valid", fifo_wvalid, 1);
        check("hold_data", fifo_wdata, prev_data);
      end
      prev_stall = fifo_wvalid && !fifo_wready && !control_hazard;
      prev_data  = fifo_wdata;
      if (fifo_wvalid && fifo_wready && !control_hazard) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc - 1;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_entry: got %h expected none", fifo_wdata);
        end else begin
          check("entry", fifo_wdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit found;
    do_reset();

    // Back-to-back fetch with 1-cycle memory and a draining queue.
    p_ready = 100; p_rd = 100; p_haz = 0; wmax = 0;
    repeat (8) cycle();
    if (acc_cyc.size() >= 3) begin
      check("seq_addr0", acc_addr[0], 32'h0);
      check("seq_addr1", acc_addr[1], 32'h4);
      check("seq_addr2", acc_addr[2], 32'h8);
      check("seq_back_to_back", acc_cyc[2] - acc_cyc[0], 2);
      check("first_entry_latency", first_wr_cyc - acc_cyc[0], 2);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL seq_accepts: got %0d expected 3", acc_cyc.size());
    end

    // Redirect to 0x100 while a slow request is outstanding.
    wmax = 3; found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      if (busy && wt > 0) found = 1;
    end
    check("redirect_setup", found, 1);
    force_haz = 1; force_tgt = 32'h100;
    cycle();
    force_haz = 0;
    repeat (12) cycle();

    // Redirect coincident with a response.
    wmax = 0; haz_on_rv = 1;
    repeat (4) cycle();
    haz_on_rv = 0;
    repeat (4) cycle();

    // Address wrap.
    force_haz = 1; force_tgt = 32'hFFFF_FFF8;
    cycle();
    force_haz = 0;
    repeat (8) cycle();
    check("pc_wrap", seen_wrap, 1);

    // Random traffic with memory stalls, queue backpressure and redirects.
    p_ready = 70; p_rd = 50; p_haz = 6; wmax = 3;
    repeat (1500) cycle();

    // Reset in the middle of traffic.
    do_reset();
    p_haz = 0;
    repeat (300) cycle();
    p_haz = 6;
    repeat (800) cycle();

    // Drain: stop issuing and let every owed entry reach the queue.
    p_ready = 0; p_rd = 100; p_haz = 0;
    repeat (20) cycle();
    check("drained", exp_q.size(), 0);
    check("saw_redirect_pending", n_hz_pend > 0, 1);
    check("saw_redirect_rvalid", n_hz_rv > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Front-end producer that drives the instruction memory bus and writes fetched instructions into the instruction queue, a `fifo` instantiated with `DATA_TYPE = FetchEntry`. It is the write-side partner of that queue: it consumes `wready`/`wready_two` and drives `wvalid`/`wdata`/`flush`. It sits between the instruction memory port and the decode-side queue in the core top level. It keeps at most one memory request outstanding and handles redirects from the execute stage.

## Interface
- `RESET_VECTOR`, default `32'h0000_0000`, first fetch address after reset.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `membus_valid`  out  1  request valid.
- `membus_ready`  in  1  memory accepts the request this cycle.
- `membus_addr`  out  XLEN  request address, word aligned.
- `membus_rvalid`  in  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance.
- `membus_rdata`  in  32  instruction word.
- `fifo_wvalid`  out  1  queue write valid.
- `fifo_wready`  in  1  queue has ≥1 free slot.
- `fifo_wready_two`  in  1  queue has ≥2 free slots.
- `fifo_wdata`  out  FetchEntry  `{addr, bits}`.
- `fifo_flush`  out  1  queue flush.
- `control_hazard`  in  1  redirect request from execute.
- `control_hazard_pc_next`  in  XLEN  redirect target.

## Operation
- State:
  - `pc` is the next fetch address.
  - `pending`: one request is outstanding.
  - `req_addr`: address of the outstanding request.
  - `discard`: drop the next response.
  - Output buffer `obuf_valid` / `obuf`.
- Issue condition (combinational): `issue_ok = !control_hazard && (!pending || membus_rvalid) && (!obuf_valid || fifo_wready) && fifo_wready_two`.
  - `membus_valid = issue_ok`; it never depends on `membus_ready`.
  - `membus_addr = pc`.
- Accept (`membus_valid && membus_ready`):
  - `req_addr <= pc`, `pc <= pc + 4` (wraps modulo 2^XLEN), `pending <= 1`.
- Response (`membus_rvalid`):
  - `pending <= 0`, unless a new request is accepted in the same cycle.
  - If `discard` is set: `discard <= 0`, and the data is dropped.
  - Otherwise: `obuf <= {req_addr, membus_rdata}` and `obuf_valid <= 1`.
- Output:
  - `fifo_wvalid = obuf_valid`, `fifo_wdata = obuf`.
  - `obuf_valid` clears on `fifo_wready`, unless it is reloaded in the same cycle.
- Redirect (`control_hazard`, has priority over everything above):
  - `fifo_flush = control_hazard`, combinational.
  - `pc <= control_hazard_pc_next`.
  - `obuf_valid <= 0`.
  - If `pending && !membus_rvalid`: `discard <= 1`.
  - A response arriving in the same cycle is dropped.
  - No request is issued that cycle.
- The `wready_two` gate guarantees queue space for both the buffered entry and the in-flight response, so a response can always be captured: `obuf` never needs to stall `membus_rvalid`.

## Timing
- Reset (async assert, sync-safe release):
  - `pc = RESET_VECTOR`; `pending`, `discard`, `obuf_valid` are 0.
  - `fifo_wvalid = 0`, `fifo_wdata = '0`.
  - `membus_valid` follows `issue_ok`, so it is 1 as soon as the queue reports two free slots.
- Latency:
  - Request accepted in cycle N.
  - Response arrives at N+1 at the earliest.
  - `fifo_wvalid` is high in N+2.
  - The entry is visible at the queue read side in N+3.
- Throughput: one instruction per cycle with a 1-cycle memory and a non-full queue.
- Backpressure: when the queue has fewer than two free slots, issue stops; the buffered entry is held stable until `fifo_wready`.
- Redirect:
  - The first request to the target is issued the cycle after `control_hazard`.
  - If a stale response is outstanding, issue waits for its `membus_rvalid`, which is discarded.
- Reset mid-operation: all state is cleared immediately. A response arriving after reset release without a matching request is a memory protocol violation; the bench never drives it.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN = 32`.
  - `typedef logic [XLEN-1:0] Addr`.
  - `typedef logic [31:0] Inst`.
  - `typedef struct packed {Addr addr; Inst bits;} FetchEntry`.
- No sub-module. The queue `fifo` (WIDTH ≥ 2) is instantiated by the core top, not inside this block.

## Test plan
- Reset release, 1-cycle memory, empty queue → requests to 0x0, 0x4, 0x8 on consecutive cycles; `fifo_wdata.addr` sequence 0x0, 0x4, 0x8, starting two cycles after the first accept.
- `membus_ready` held low 3 cycles after the first accept → `membus_addr` holds 0x4, no duplicate entries, order preserved.
- Queue `wready_two=0`, `wready=1` with `obuf` full → no new request; `obuf` drains; issue resumes the cycle `wready_two` returns to 1.
- `control_hazard` to 0x100 while a request to 0x8 is outstanding → `fifo_flush` pulses 1 cycle; the 0x8 response is dropped; the next entry has addr 0x100.
- `control_hazard` in the same cycle as `membus_rvalid` → that response is dropped, `discard` stays 0, and a fetch to the target is issued the next cycle.
- `pc` = 0xFFFF_FFFC accepted → next `membus_addr` = 0x0000_0000.
